// File: rtl/line_fill_ram_if.sv
// Cache-to-RAM line interface.
// One 64-bit line per request, completed by a done pulse.
interface line_fill_ram_if;
    logic        req;
    logic        r_w;
    logic [31:0] address_to_ram;
    logic [63:0] data_to_ram;
    logic [63:0] data_from_ram;
    logic        ram_access_done;
    logic        ram_err;
    logic        busy;

    modport master (
        output req,
        output r_w,
        output address_to_ram,
        output data_to_ram,
        input  data_from_ram,
        input  ram_access_done,
        input  ram_err,
        input  busy
    );

    modport slave (
        input  req,
        input  r_w,
        input  address_to_ram,
        input  data_to_ram,
        output data_from_ram,
        output ram_access_done,
        output ram_err,
        output busy
    );
endinterface

// File: rtl/line_fill_ram.sv
// Line-fill RAM responder: fixed-latency 64-bit line read/write.
// Request fields are captured at acceptance and held until done.
module line_fill_ram #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic           clk,
    input  logic           reset,
    line_fill_ram_if.slave bus
);
    localparam int         DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [3:0] LP_CNT_LD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_HOLD
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nxt;
    logic                    w_accept;
    logic                    w_fire;

    logic [28:0]             r_line;
    logic                    r_rw;
    logic [63:0]             r_wdata;

    logic [63:0]             r_mem [DEPTH];
    logic [63:0]             r_dout;
    logic                    r_done;
    logic                    r_err;

    logic [DEPTH_LOG2-1:0]   w_idx;
    logic                    w_oor;

    assign w_idx = r_line[DEPTH_LOG2-1:0];
    assign w_oor = (r_line >> DEPTH_LOG2) != '0;

    // Next-state and counter logic; w_fire marks the access edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_fire      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = LP_CNT_LD;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_fire      = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!bus.req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture request fields at acceptance; later input changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_line  <= '0;
            r_rw    <= 1'b0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_line  <= bus.address_to_ram[31:3];
            r_rw    <= bus.r_w;
            r_wdata <= bus.data_to_ram;
        end
    end

    // Completion pulse, error flag and read data return.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_dout <= '0;
        end else begin
            r_done <= w_fire;
            r_err  <= w_fire && w_oor;
            if (w_fire) begin
                if (w_oor) begin
                    r_dout <= '0;
                end else if (!r_rw) begin
                    r_dout <= r_mem[w_idx];
                end
            end
        end
    end

    // Line array write; a reset mid-transaction leaves state IDLE, so no write.
    always_ff @(posedge clk) begin
        if (w_fire && r_rw && !w_oor) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign bus.data_from_ram   = r_dout;
    assign bus.ram_access_done = r_done;
    assign bus.ram_err         = r_err;
    assign bus.busy            = (r_state != S_IDLE);
endmodule

// File: tb/tb_line_fill_ram.sv
// Testbench for line_fill_ram: directed scenarios plus random traffic
// checked against a line-array model.
module tb_line_fill_ram;
    localparam int DL  = 8;
    localparam int LAT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    line_fill_ram_if bus ();

    line_fill_ram #(
        .DEPTH_LOG2(DL),
        .LATENCY   (LAT)
    ) u_dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] m_mem [int];
    logic [63:0] m_dout;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic rw, input logic [31:0] a,
                       input logic [63:0] d, input int hold,
                       input bit perturb);
        int  n;
        bit  got;
        bit  oor;
        int  idx;
        @(negedge clk);
        bus.req            = 1'b1;
        bus.r_w            = rw;
        bus.address_to_ram = a;
        bus.data_to_ram    = d;
        @(posedge clk);
        #1;
        chk("busy_on_accept", 64'(bus.busy), 64'd1);
        got = 0;
        n   = 0;
        while (!got && n < LAT + 4) begin
            if (perturb && n == 1) begin
                @(negedge clk);
                bus.address_to_ram = 32'h18;
                bus.r_w            = 1'b1;
                bus.data_to_ram    = {$urandom, $urandom};
            end
            @(posedge clk);
            #1;
            n++;
            if (bus.ram_access_done === 1'b1) got = 1;
        end
        chk("done_latency", 64'(n), 64'(LAT));
        oor = (a >> (DL + 3)) != 0;
        idx = int'((a >> 3) & 32'hFF);
        if (got) begin
            if (oor) m_dout = '0;
            else if (!rw) m_dout = m_mem[idx];
            else m_mem[idx] = d;
            chk("done_err", 64'(bus.ram_err), 64'(oor));
            chk("done_data", bus.data_from_ram, m_dout);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_no_done", 64'(bus.ram_access_done), 64'd0);
            chk("hold_busy", 64'(bus.busy), 64'd1);
        end
        @(negedge clk);
        bus.req = 1'b0;
        @(posedge clk);
        #1;
        chk("release_done", 64'(bus.ram_access_done), 64'd0);
        chk("release_busy", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [63:0] d;
        int          ln;
        bus.req            = 1'b0;
        bus.r_w            = 1'b0;
        bus.address_to_ram = '0;
        bus.data_to_ram    = '0;
        m_dout             = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", bus.data_from_ram, 64'd0);
        chk("rst_done", 64'(bus.ram_access_done), 64'd0);
        chk("rst_err", 64'(bus.ram_err), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("idle_no_done", 64'(bus.ram_access_done), 64'd0);
        end

        txn(1'b1, 32'h10, 64'hDEADBEEF_01234567, 0, 0);
        txn(1'b0, 32'h14, '0, 0, 0);
        chk("raw_line2", bus.data_from_ram, 64'hDEADBEEF_01234567);

        txn(1'b1, 32'h0, 64'h0123_4567_89AB_CDEF, 0, 0);
        txn(1'b1, 32'h8, 64'h1111_2222_3333_4444, 0, 0);
        txn(1'b1, 32'h18, 64'h3333_3333_CAFE_F00D, 0, 0);

        txn(1'b0, 32'h10, '0, 10, 0);

        txn(1'b0, 32'h800, '0, 0, 0);
        txn(1'b0, 32'h0, '0, 0, 0);

        txn(1'b0, 32'h8, '0, 0, 1);
        txn(1'b0, 32'h18, '0, 0, 0);

        txn(1'b1, 32'h20, 64'h5555_5555_5555_5555, 0, 0);
        @(negedge clk);
        bus.req            = 1'b1;
        bus.r_w            = 1'b1;
        bus.address_to_ram = 32'h20;
        bus.data_to_ram    = 64'hAAAA_AAAA_AAAA_AAAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = 1'b0;
        m_dout  = '0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_dout", bus.data_from_ram, 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", 64'(bus.ram_access_done), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 32'h20, '0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            txn(1'b1, 32'(i) << 3, {$urandom, $urandom}, 0, 0);
        end
        for (int k = 0; k < 40; k++) begin
            ln = int'($urandom % 8);
            a  = (32'(ln) << 3) | 32'($urandom % 8);
            if ($urandom % 6 == 0) begin
                a = a | (32'($urandom_range(1, 255)) << 11);
            end
            d = {$urandom, $urandom};
            txn(1'($urandom % 2), a, d, int'($urandom % 3), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/line_fill_ram.md
Name: line_fill_ram

Overview:
Main-memory responder on the cache-to-RAM line interface. It accepts one 64-bit-line read or write request from a cache controller and services it after a fixed, configurable access latency. It then returns the line with a one-cycle ram_access_done pulse. It is the RAM end of the interface that the instruction cache drives, and is used both as the simulation backing store and as the synthesizable on-chip memory.

Parameters:
DEPTH_LOG2, 8, log2 of number of 64-bit lines (256 lines = 2 KiB).
LATENCY, 4, clock edges from request acceptance to ram_access_done; legal range 1..15.

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset.
req  input  1  request strobe; level, held by requester until it sees ram_access_done.
r_w  input  1  0 = read line, 1 = write line.
address_to_ram  input  32  byte address; bits [2:0] ignored (line aligned); line index = [DEPTH_LOG2+2:3].
data_to_ram  input  64  write line data.
data_from_ram  output  64  read line data; bits [31:0] = word at block offset 0, [63:32] = offset 1.
ram_access_done  output  1  one-cycle completion pulse.
ram_err  output  1  qualifies ram_access_done; 1 = address out of range.
busy  output  1  high from acceptance until return to IDLE.

Behaviour:
- Reset (reset low, asynchronous): state IDLE, data_from_ram=0, ram_access_done=0, ram_err=0, busy=0, counter=0. Memory array is not cleared; contents are undefined until written.
- Reset asserted mid-operation aborts the transaction. A pending write is not performed, and no done pulse is issued.
- FSM states: IDLE, BUSY, HOLD.
- IDLE:
  - On an edge with req=1, capture address, r_w and data_to_ram.
  - Load counter with LATENCY-1, set busy=1, go to BUSY.
- BUSY:
  - Captured values are used; changes on the inputs are ignored.
  - If counter != 0, decrement it.
  - If counter == 0, perform the access on this edge, set ram_access_done=1, and go to HOLD.
- Access rules:
  - Read: data_from_ram <= mem[index].
  - Write: mem[index] <= captured data; data_from_ram unchanged.
  - Out of range (any captured bit [31:DEPTH_LOG2+3] nonzero): no array access, data_from_ram <= 0, ram_err=1.
  - ram_err is otherwise 0 when done pulses.
- Timing: with acceptance at edge T0, ram_access_done is high for exactly the cycle following edge T0+LATENCY. For LATENCY=1 this is the cycle after the next edge.
- HOLD:
  - ram_access_done is cleared on the first HOLD edge.
  - Stay in HOLD while req=1; go to IDLE (busy=0) on the first edge with req=0.
  - This guarantees that a req held across done is never served twice.
  - New requests are accepted only in IDLE, so the minimum gap between done pulses is LATENCY+2 cycles.
- data_from_ram holds its value from one read completion until the next read completion, an error, or reset.
- Read-after-write to the same line returns the written data. Writes are committed at their done edge.
- Simultaneous req and reset: reset wins.

Test Plan:
- Reset then idle: reset low 2 cycles, req=0 -> data_from_ram=0, done=0, err=0, busy=0, no done pulse for 20 cycles.
- Write/read latency: write addr 0x00000010, data 0xDEADBEEF_01234567, LATENCY=4 -> done high one cycle exactly 4 edges after accept. Read of 0x00000014 (same line) -> data_from_ram=0xDEADBEEF_01234567 with done 4 edges after accept.
- Held req: keep req=1 for 10 cycles after done -> exactly one done pulse, busy stays 1. Drop req -> busy=0 next edge. Re-raise req -> new transaction accepted.
- Out of range: read 0x00000800 with DEPTH_LOG2=8 -> done with err=1, data_from_ram=0. A prior write of line 0 is unaffected (read 0x0 returns its data).
- Input change during BUSY: read 0x8, then switch address to 0x18 and r_w=1 mid-BUSY -> returns line 1 data, and line 3 is not written (verified by subsequent read).
- Reset mid-write: write 0x20 with 0xAAAA..., assert reset at counter=1 -> no done pulse. Subsequent read of 0x20 returns the previously written value 0x5555....
